fft_mem_sched: RTL and testbench

- Sequencing controller for the 64-entry dual-port sample RAM in the real-FFT core.
- Runs one in-place radix-2 DIT transform per Start:
  - LOAD: writes input samples into the RAM in bit-reversed order.
  - COMPUTE: issues LOG2N stages of butterfly read/write-back addresses on RAM ports A/B, with twiddle index and butterfly strobes.
  - UNLOAD: streams results out in natural order.
- Drives RAM control (En, We_A, We_B, Addr_A, Addr_B) and the datapath muxes. It never touches sample data.

---
 rtl/fft_mem_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_fft_mem_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mem_sched.sv
// fft_mem_sched: sequencing controller for the dual-port sample RAM of the real-FFT core.
// One in-place radix-2 DIT transform per Start: LOAD writes samples in bit-reversed order,
// COMPUTE walks LOG2N stages of butterflies (read, Bf_Go, wait BF_LAT, write-back), UNLOAD
// streams results in natural order. Only RAM control and datapath mux selects are driven.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Start               begin a transform (taken only while idle)
//   In_Valid / In_Ready input sample handshake during LOAD
//   Out_Valid, Out_Idx  RAM port A holds result sample Out_Idx
//   Mode                datapath mux select (0 idle, 1 load, 2 compute, 3 unload)
//   Bf_Go, Tw_Idx       butterfly operands valid this cycle, twiddle index
//   Stage               current butterfly stage
//   En, We_A, We_B      RAM enable and per-port write enables
//   Addr_A, Addr_B      RAM port addresses
//   Busy, Done          activity flag, one-cycle completion pulse
//
// Every output is a register, so each RAM action appears the cycle after the controller
// decides on it (e.g. a sample accepted in cycle t is written in cycle t+1).
module fft_mem_sched #(
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned BF_LAT = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Out_Valid,
  output logic [LOG2N-1:0] Out_Idx,
  output logic [1:0]       Mode,
  output logic             Bf_Go,
  output logic [LOG2N-2:0] Tw_Idx,
  output logic [2:0]       Stage,
  output logic             En,
  output logic             We_A,
  output logic             We_B,
  output logic [LOG2N-1:0] Addr_A,
  output logic [LOG2N-1:0] Addr_B,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {StIdle, StLoad, StComp, StUnload} state_e;

  // Phase index of the write-back cycle inside one butterfly.
  localparam logic [4:0] PhLast = 5'(BF_LAT + 1);
  localparam logic [LOG2N-1:0] AOne = {{(LOG2N-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [LOG2N:0]     cnt_q, cnt_d;      // load/unload sample counter, MSB flags 2^LOG2N
  logic [LOG2N-2:0]   k_q, k_d;          // butterfly index within a stage
  logic [2:0]         s_q, s_d;          // stage
  logic [4:0]         ph_q, ph_d;        // cycle within the current butterfly

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [LOG2N-1:0]   out_idx_q, out_idx_d;
  logic [1:0]         mode_q, mode_d;
  logic               bf_go_q, bf_go_d;
  logic [LOG2N-2:0]   tw_q, tw_d;
  logic [2:0]         stage_q, stage_d;
  logic               en_q, en_d;
  logic               we_a_q, we_a_d;
  logic               we_b_q, we_b_d;
  logic [LOG2N-1:0]   addr_a_q, addr_a_d;
  logic [LOG2N-1:0]   addr_b_q, addr_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LOG2N-1:0]   rev;
  logic [LOG2N-1:0]   k_ext, h, pos, grp, bf_a, bf_b;
  logic [LOG2N-2:0]   tw;

  // Bit-reversed load address and butterfly addressing for (s_q, k_q).
  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      rev[i] = cnt_q[LOG2N-1-i];
    end
    k_ext = {1'b0, k_q};
    h     = AOne << s_q;
    pos   = k_ext & (h - AOne);
    grp   = k_ext >> s_q;
    bf_a  = (grp << (s_q + 3'd1)) | pos;
    bf_b  = bf_a + h;
    // pos < 2^(LOG2N-1), so its top bit is always zero here.
    tw    = pos[LOG2N-2:0] << (3'(LOG2N - 1) - s_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    s_d         = s_q;
    ph_d        = ph_q;
    out_valid_d = 1'b0;
    out_idx_d   = '0;
    mode_d      = 2'd0;
    bf_go_d     = 1'b0;
    tw_d        = '0;
    stage_d     = '0;
    en_d        = 1'b0;
    we_a_d      = 1'b0;
    we_b_d      = 1'b0;
    addr_a_d    = '0;
    addr_b_d    = '0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // busy_q is still high on the Done cycle, which keeps Start ignored there.
        if (Start && !busy_q) begin
          state_d = StLoad;
          mode_d  = 2'd1;
        end
      end
      StLoad: begin
        mode_d = 2'd1;
        if (In_Valid) begin
          en_d     = 1'b1;
          we_a_d   = 1'b1;
          addr_a_d = rev;
          if (cnt_q[LOG2N-1:0] == '1) begin
            cnt_d   = '0;
            state_d = StComp;
          end else begin
            cnt_d = cnt_q + (LOG2N+1)'(1);
          end
        end
      end
      StComp: begin
        mode_d   = 2'd2;
        addr_a_d = bf_a;
        addr_b_d = bf_b;
        stage_d  = s_q;
        tw_d     = tw;
        bf_go_d  = (ph_q == 5'd1);
        if (ph_q == PhLast) begin
          en_d   = 1'b1;
          we_a_d = 1'b1;
          we_b_d = 1'b1;
          ph_d   = '0;
          if (k_q == '1) begin
            k_d = '0;
            if (s_q == 3'(LOG2N - 1)) begin
              s_d     = '0;
              state_d = StUnload;
            end else begin
              s_d = s_q + 3'd1;
            end
          end else begin
            k_d = k_q + (LOG2N-1)'(1);
          end
        end else begin
          en_d = (ph_q == '0);
          ph_d = ph_q + 5'd1;
        end
      end
      StUnload: begin
        mode_d = 2'd3;
        if (!cnt_q[LOG2N]) begin
          en_d     = 1'b1;
          addr_a_d = cnt_q[LOG2N-1:0];
          cnt_d    = cnt_q + (LOG2N+1)'(1);
        end else begin
          cnt_d   = '0;
          state_d = StIdle;
        end
        // A read issued this cycle shows up on port A next cycle.
        out_valid_d = en_q && (mode_q == 2'd3);
        out_idx_d   = out_valid_d ? addr_a_q : '0;
        done_d      = out_valid_d && (addr_a_q == '1);
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StLoad);
    busy_d     = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      k_q         <= '0;
      s_q         <= '0;
      ph_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      mode_q      <= 2'd0;
      bf_go_q     <= 1'b0;
      tw_q        <= '0;
      stage_q     <= '0;
      en_q        <= 1'b0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      s_q         <= s_d;
      ph_q        <= ph_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      mode_q      <= mode_d;
      bf_go_q     <= bf_go_d;
      tw_q        <= tw_d;
      stage_q     <= stage_d;
      en_q        <= en_d;
      we_a_q      <= we_a_d;
      we_b_q      <= we_b_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Out_Idx   = out_idx_q;
  assign Mode      = mode_q;
  assign Bf_Go     = bf_go_q;
  assign Tw_Idx    = tw_q;
  assign Stage     = stage_q;
  assign En        = en_q;
  assign We_A      = we_a_q;
  assign We_B      = we_b_q;
  assign Addr_A    = addr_a_q;
  assign Addr_B    = addr_b_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_fft_mem_sched.sv
// Bench for fft_mem_sched: a timeline model builds the expected per-cycle outputs of a whole
// transform from the input handshake pattern, and every cycle is compared against the DUT.
// Two instances cover BF_LAT=2 and BF_LAT=0.
module tb_fft_mem_sched;
  localparam int LOG2N = 6;
  localparam int N     = 64;
  localparam int MaxC  = 1300;

  typedef struct packed {
    logic       in_ready;
    logic       en;
    logic       we_a;
    logic       we_b;
    logic [5:0] addr_a;
    logic [5:0] addr_b;
    logic [1:0] mode;
    logic       bf_go;
    logic [4:0] tw;
    logic [2:0] stage;
    logic       out_valid;
    logic [5:0] out_idx;
    logic       busy;
    logic       done;
  } obs_t;

  logic Clk = 1'b0;
  logic Rst, start, In_Valid, sel;
  logic start2, start0;
  assign start2 = start & ~sel;
  assign start0 = start & sel;

  logic p_in_ready, p_out_valid, p_bf_go, p_en, p_we_a, p_we_b, p_busy, p_done;
  logic [5:0] p_out_idx, p_addr_a, p_addr_b;
  logic [1:0] p_mode;
  logic [4:0] p_tw;
  logic [2:0] p_stage;
  logic q_in_ready, q_out_valid, q_bf_go, q_en, q_we_a, q_we_b, q_busy, q_done;
  logic [5:0] q_out_idx, q_addr_a, q_addr_b;
  logic [1:0] q_mode;
  logic [4:0] q_tw;
  logic [2:0] q_stage;

  fft_mem_sched #(.LOG2N(6), .BF_LAT(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .Start(start2), .In_Valid(In_Valid), .In_Ready(p_in_ready),
    .Out_Valid(p_out_valid), .Out_Idx(p_out_idx), .Mode(p_mode), .Bf_Go(p_bf_go),
    .Tw_Idx(p_tw), .Stage(p_stage), .En(p_en), .We_A(p_we_a), .We_B(p_we_b),
    .Addr_A(p_addr_a), .Addr_B(p_addr_b), .Busy(p_busy), .Done(p_done)
  );

  fft_mem_sched #(.LOG2N(6), .BF_LAT(0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Start(start0), .In_Valid(In_Valid), .In_Ready(q_in_ready),
    .Out_Valid(q_out_valid), .Out_Idx(q_out_idx), .Mode(q_mode), .Bf_Go(q_bf_go),
    .Tw_Idx(q_tw), .Stage(q_stage), .En(q_en), .We_A(q_we_a), .We_B(q_we_b),
    .Addr_A(q_addr_a), .Addr_B(q_addr_b), .Busy(q_busy), .Done(q_done)
  );

  obs_t o2, o0, obs;
  assign o2 = {p_in_ready, p_en, p_we_a, p_we_b, p_addr_a, p_addr_b, p_mode, p_bf_go, p_tw,
               p_stage, p_out_valid, p_out_idx, p_busy, p_done};
  assign o0 = {q_in_ready, q_en, q_we_a, q_we_b, q_addr_a, q_addr_b, q_mode, q_bf_go, q_tw,
               q_stage, q_out_valid, q_out_idx, q_busy, q_done};
  assign obs = sel ? o0 : o2;

  always #5 Clk = ~Clk;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t ex  [0:MaxC-1];
  bit   ivs [0:MaxC-1];
  int   acc [0:N-1];
  int   t0, u0, dcyc, ncyc;

  task automatic chk(input string tag, input int c, input logic [35:0] got,
                     input logic [35:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, got, want);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (v[i]) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // Fields the controller leaves undefined in a given cycle are not compared.
  function automatic obs_t msk_of(input obs_t e);
    obs_t m = '1;
    if (!(e.en || e.mode == 2'd2)) m.addr_a = '0;
    if (!e.bf_go) m.tw = '0;
    if (e.mode != 2'd2) m.stage = '0;
    if (!e.out_valid) m.out_idx = '0;
    return m;
  endfunction

  task automatic gen_iv(input int kind);
    for (int c = 0; c < MaxC; c++) begin
      case (kind)
        0:       ivs[c] = 1'b1;
        1:       ivs[c] = !(c >= 12 && c <= 16);
        default: ivs[c] = (c >= 300) || ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Expected outputs by cycle, cycle 0 being the one on which Start is applied.
  task automatic build(input int lat);
    int   i, b, r;
    obs_t e;
    foreach (ex[c]) ex[c] = '0;
    i = 0;
    for (int c = 1; i < N; c++) begin
      ex[c].in_ready = 1'b1;
      ex[c].mode     = 2'd1;
      ex[c].busy     = 1'b1;
      if (ivs[c]) begin
        acc[i] = c;
        i++;
      end
    end
    for (int j = 0; j < N; j++) begin
      r = acc[j] + 1;
      ex[r].en     = 1'b1;
      ex[r].we_a   = 1'b1;
      ex[r].addr_a = 6'(brev(j));
      ex[r].mode   = 2'd1;
      ex[r].busy   = 1'b1;
    end
    t0 = acc[N-1] + 2;
    b  = 0;
    for (int s = 0; s < LOG2N; s++) begin
      for (int base = 0; base < N; base += (2 << s)) begin
        for (int j = 0; j < (1 << s); j++) begin
          r = t0 + b * (lat + 2);
          for (int t = 0; t <= lat + 1; t++) begin
            e        = '0;
            e.mode   = 2'd2;
            e.busy   = 1'b1;
            e.addr_a = 6'(base + j);
            e.addr_b = 6'(base + j + (1 << s));
            e.stage  = 3'(s);
            e.en     = (t == 0) || (t == lat + 1);
            e.we_a   = (t == lat + 1);
            e.we_b   = e.we_a;
            e.bf_go  = (t == 1);
            if (e.bf_go) e.tw = 5'(j * ((N / 2) >> s));
            ex[r+t]  = e;
          end
          b++;
        end
      end
    end
    u0 = t0 + b * (lat + 2);
    for (int j = 0; j < N; j++) begin
      ex[u0+j].en          = 1'b1;
      ex[u0+j].addr_a      = 6'(j);
      ex[u0+j].mode        = 2'd3;
      ex[u0+j].busy        = 1'b1;
      ex[u0+j+1].out_valid = 1'b1;
      ex[u0+j+1].out_idx   = 6'(j);
      ex[u0+j+1].mode      = 2'd3;
      ex[u0+j+1].busy      = 1'b1;
    end
    dcyc          = u0 + N;
    ex[dcyc].done = 1'b1;
    ncyc          = dcyc + 3;
  endtask

  task automatic run(input bit which, input int lat, input int kind, input bit abort,
                     input int want_done);
    int   done_at, abort_c;
    obs_t m;
    sel = which;
    gen_iv(kind);
    build(lat);
    abort_c = abort ? t0 + 3 * (N / 2) * (lat + 2) + 2 : -1;
    done_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      // Random Start while busy, and on the Done cycle, must be ignored.
      start    = (c == 0 || c == dcyc) ? 1'b1 : (c < dcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      In_Valid = ivs[c];
      Rst      = (c == abort_c);
      m        = msk_of(ex[c]);
      chk("trace", c, obs & m, ex[c]);
      if (obs.done && done_at < 0) done_at = c;
      if (which == 1'b0 && kind == 0) begin
        if (c == t0)              chk("s0k0_addr", c, {obs.addr_a, obs.addr_b}, {6'd0, 6'd1});
        if (c == t0 + 1)          chk("s0k0_go", c, {obs.bf_go, obs.tw}, {1'b1, 5'd0});
        if (c == t0 + 3)          chk("s0k0_wr", c, {obs.en, obs.we_a, obs.we_b, obs.addr_a,
                                      obs.addr_b}, {3'b111, 6'd0, 6'd1});
        if (c == t0 + 69 * 4)     chk("s2k5_addr", c, {obs.addr_a, obs.addr_b, obs.stage},
                                      {6'd9, 6'd13, 3'd2});
        if (c == t0 + 69 * 4 + 1) chk("s2k5_tw", c, obs.tw, 5'd8);
        if (c == t0 + 191 * 4)    chk("s5k31_addr", c, {obs.addr_a, obs.addr_b, obs.stage},
                                      {6'd31, 6'd63, 3'd5});
        if (c == t0 + 191 * 4 + 1) chk("s5k31_tw", c, obs.tw, 5'd31);
        if (c == u0 + 1)          chk("first_out", c, {obs.out_valid, obs.out_idx}, {1'b1, 6'd0});
        if (c == dcyc)            chk("done_last", c, {obs.done, obs.out_valid, obs.out_idx},
                                      {1'b1, 1'b1, 6'd63});
        if (c == dcyc + 1)        chk("start_on_done", c, obs.busy, 1'b0);
      end
      if (which == 1'b0 && kind == 1) begin
        if (c == acc[10] + 2)     chk("bp_hold", c, {obs.en, obs.we_a}, 2'b00);
        if (c == acc[11] + 1)     chk("bp_s11", c, {obs.we_a, obs.addr_a}, {1'b1, 6'd52});
      end
      if (which == 1'b1 && c == t0 + 1) begin
        chk("lat0_go_wr", c, {obs.bf_go, obs.en, obs.we_a, obs.we_b}, 4'b1111);
      end
      @(posedge Clk);
      #1;
      if (c == abort_c) begin
        chk("reset_clear", c + 1, obs, '0);
        Rst = 1'b0;
        break;
      end
    end
    start    = 1'b0;
    In_Valid = 1'b0;
    if (want_done > 0) chk("latency", done_at, done_at, want_done);
  endtask

  initial begin
    Rst      = 1'b1;
    start    = 1'b0;
    In_Valid = 1'b0;
    sel      = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_lat2", 0, o2, '0);
    chk("reset_lat0", 0, o0, '0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    run(1'b0, 2, 0, 1'b0, 1 + 64 + 768 + 65);
    run(1'b0, 2, 1, 1'b0, 0);
    run(1'b0, 2, 2, 1'b1, 0);
    run(1'b0, 2, 2, 1'b0, 0);
    run(1'b1, 0, 0, 1'b0, 1 + 64 + 384 + 65);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
